tile_sched: RTL and testbench
=============================

# tile_sched

Tile-level scheduler for the systolic matrix-multiply datapath. It accepts a job of R×C output tiles, each reduced over K input blocks. For every block it issues one start pulse to the A/B scatter feeders and waits for both to report their feed complete. After the last K block it waits out the array drain latency, then hands the tile to the writeback engine with a req/ack handshake. It sits between the host control registers and the scatter/writeback units.

## Interface
Parameters:
- `CW`, default 8: width of the tile-count configuration and tile-index fields.
- `DRAIN_CYC`, default 128: cycles from the last feed completion to valid array outputs. Must be ≥1.
- `DRW`, default 8: width of the drain counter. Must satisfy 2^DRW > DRAIN_CYC.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  job start pulse. Sampled only in IDLE.
- `abort`  in  1  cancels the job. Ignored in IDLE.
- `cfg_rows`, `cfg_cols`, `cfg_ks`  in  CW each  tile counts. Latched on an accepted start.
- `feed_start`  out  1  one-cycle pulse that starts both scatter feeders.
- `feed_done_a`, `feed_done_b`  in  1 each  feed-complete pulses from the A and B scatter units.
- `tile_row`, `tile_col`, `tile_k`  out  CW each  current tile indices.
- `acc_clear`  out  1  qualifies `feed_start`. 1 when `tile_k==0`, telling the array to clear its accumulators.
- `wb_req`  out  1  tile result ready. Held high until acked.
- `wb_ack`  in  1  writeback accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job completion.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected because of a zero count.
- `aborted`  out  1  one-cycle pulse when an abort is taken.
- `state_dbg`  out  3  current state encoding.

## Operation
- States and encodings: IDLE=0, ISSUE=1, FEED=2, DRAIN=3, WB=4, FIN=5.
- IDLE, on `start`:
  - If any cfg field is 0: pulse `cfg_err`, stay in IDLE.
  - Otherwise: latch the config, clear the indices, go to ISSUE.
- ISSUE: `feed_start`=1 for this single cycle; `acc_clear`=(`tile_k`==0). Clear the sticky done flags. Go to FEED.
- FEED:
  - Sticky flags `da`/`db` set on `feed_done_a`/`feed_done_b`. The pulses may arrive in any order or in the same cycle, including the cycle right after ISSUE.
  - The phase completes in the cycle where (`da`|`feed_done_a`)&(`db`|`feed_done_b`) holds.
  - On completion: if `tile_k`<ks-1, increment `tile_k` and go to ISSUE. Otherwise load the drain counter with DRAIN_CYC-1 and go to DRAIN.
- DRAIN: decrement each cycle. When the counter is 0, go to WB. DRAIN therefore lasts exactly DRAIN_CYC cycles.
- WB:
  - `wb_req`=1, and the indices stay stable while it is high.
  - On `wb_ack` (acceptance is allowed in the first WB cycle): `tile_k`←0 and advance the column-major-inner order: `tile_col`++, wrapping to 0 with `tile_row`++.
  - After the last tile (rows-1, cols-1): go to FIN. Otherwise go to ISSUE.
- FIN: pulse `done`, go to IDLE.
- `abort` in any non-IDLE state has priority over every other transition:
  - Next state is IDLE, `aborted` pulses, and no `feed_start`, `wb_req` or `done` is issued in that cycle.
  - Indices hold their values. Any pending `wb_req` drops.
- `start` while `busy` is ignored.
- Index arithmetic is unsigned CW-bit. Comparisons use the latched counts minus 1; counts of 2^CW-1 are legal.

## Timing
- Reset values: state IDLE; all outputs 0, including indices and `state_dbg`.
- `start` accepted at cycle t: `busy`=1 and `feed_start`=1 at t+1.
- A feed phase completing at cycle f leads to the next `feed_start` at f+1 (same tile), or DRAIN from f+1 to f+DRAIN_CYC.
- `wb_req` rises at f+DRAIN_CYC+1.
- `wb_ack` at cycle w leads to the next `feed_start` at w+1, or `done` at w+1 followed by IDLE at w+2.
- Minimum per-tile overhead beyond feeds: DRAIN_CYC+1+ks cycles.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- `rst` mid-job returns to reset values on the next edge and produces no `done` or `aborted` pulse.

## Configuration
- `TILE_SCHED_PERF_EN`, when defined, adds two outputs:
  - `perf_busy_cyc` [31:0]: counts cycles with `busy`=1.
  - `perf_stall_cyc` [31:0]: counts FEED cycles with the phase incomplete, plus WB cycles with `wb_ack`=0.
  - Both counters clear on an accepted `start` and on `rst`, saturate at 2^32-1, and hold after `done` or `abort`.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Single tile: rows=cols=ks=1, DRAIN_CYC=4, both feed dones 3 cycles after `feed_start`, `wb_ack` tied 1 -> exactly one `feed_start` with `acc_clear`=1, `wb_req` 5 cycles after the feed completes, `done` the cycle after the ack.
- Full job 2×2×3 with immediate dones -> 12 `feed_start` pulses; `acc_clear` on pulses 1,4,7,10; `wb_req` tile order (0,0),(0,1),(1,0),(1,1); exactly one `done`.
- Skewed feeds: `feed_done_a` at +2 and `feed_done_b` at +7; then both in the same cycle; then b before a -> completion is taken on the later pulse each time, with no double-count.
- Backpressure: `wb_ack` delayed 3 cycles -> `wb_req` high for 4 cycles with indices stable; the next `feed_start` occurs the cycle after the ack.
- Abort in DRAIN, then `start` with `cfg_cols`=0, then a valid start -> `aborted` pulse with no `done`; `cfg_err` pulse with `busy` staying 0; the valid job then completes normally.
- With `TILE_SCHED_PERF_EN`: the single-tile case with a 3-cycle ack delay gives `perf_stall_cyc`=3 plus the FEED wait cycles, and `perf_busy_cyc` equal to the total non-IDLE cycles.

Source files
------------

// File: rtl/tile_sched.sv
// Tile-level scheduler: issues K feed phases per output tile, waits out the array drain,
// then hands each tile to writeback. Optional perf counters under `TILE_SCHED_PERF_EN.
module tile_sched #(
    parameter int unsigned CW        = 8,
    parameter int unsigned DRAIN_CYC = 128,
    parameter int unsigned DRW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_rows,
    input  logic [CW-1:0] cfg_cols,
    input  logic [CW-1:0] cfg_ks,
    output logic          feed_start,
    input  logic          feed_done_a,
    input  logic          feed_done_b,
    output logic [CW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic [CW-1:0] tile_k,
    output logic          acc_clear,
    output logic          wb_req,
    input  logic          wb_ack,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          aborted,
    output logic [2:0]    state_dbg
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_busy_cyc,
    output logic [31:0]   perf_stall_cyc
`endif
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StFeed  = 3'd2,
        StDrain = 3'd3,
        StWb    = 3'd4,
        StFin   = 3'd5
    } state_e;

    state_e         r_state;
    logic [CW-1:0]  r_rows_m1, r_cols_m1, r_ks_m1;
    logic [CW-1:0]  r_tile_row, r_tile_col, r_tile_k;
    logic [DRW-1:0] r_drain_cnt;
    logic           r_da, r_db;
    logic           r_feed_start, r_acc_clear, r_wb_req, r_busy, r_done, r_cfg_err, r_aborted;

    logic w_cfg_ok;
    logic w_feed_cmp;
    logic w_last_tile;

    assign w_cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_ks != '0);
    // Sticky flag or the live pulse: completion may land on the same cycle as the later pulse.
    assign w_feed_cmp  = (r_da | feed_done_a) & (r_db | feed_done_b);
    assign w_last_tile = (r_tile_row == r_rows_m1) && (r_tile_col == r_cols_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_rows_m1    <= '0;
            r_cols_m1    <= '0;
            r_ks_m1      <= '0;
            r_tile_row   <= '0;
            r_tile_col   <= '0;
            r_tile_k     <= '0;
            r_drain_cnt  <= '0;
            r_da         <= 1'b0;
            r_db         <= 1'b0;
            r_feed_start <= 1'b0;
            r_acc_clear  <= 1'b0;
            r_wb_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_feed_start <= 1'b0;
            r_acc_clear  <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_aborted    <= 1'b0;
            if (abort && (r_state != StIdle)) begin
                r_state   <= StIdle;
                r_aborted <= 1'b1;
                r_busy    <= 1'b0;
                r_wb_req  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start) begin
                            if (!w_cfg_ok) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_rows_m1    <= cfg_rows - CW'(1);
                                r_cols_m1    <= cfg_cols - CW'(1);
                                r_ks_m1      <= cfg_ks - CW'(1);
                                r_tile_row   <= '0;
                                r_tile_col   <= '0;
                                r_tile_k     <= '0;
                                r_state      <= StIssue;
                                r_busy       <= 1'b1;
                                r_feed_start <= 1'b1;
                                r_acc_clear  <= 1'b1;
                            end
                        end
                    end
                    StIssue: begin
                        r_da    <= 1'b0;
                        r_db    <= 1'b0;
                        r_state <= StFeed;
                    end
                    StFeed: begin
                        if (feed_done_a) r_da <= 1'b1;
                        if (feed_done_b) r_db <= 1'b1;
                        if (w_feed_cmp) begin
                            if (r_tile_k < r_ks_m1) begin
                                r_tile_k     <= r_tile_k + CW'(1);
                                r_state      <= StIssue;
                                r_feed_start <= 1'b1;
                            end else begin
                                r_drain_cnt <= DRW'(DRAIN_CYC - 1);
                                r_state     <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        if (r_drain_cnt == '0) begin
                            r_state  <= StWb;
                            r_wb_req <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DRW'(1);
                        end
                    end
                    StWb: begin
                        if (wb_ack) begin
                            r_wb_req <= 1'b0;
                            r_tile_k <= '0;
                            if (r_tile_col == r_cols_m1) begin
                                r_tile_col <= '0;
                                r_tile_row <= r_tile_row + CW'(1);
                            end else begin
                                r_tile_col <= r_tile_col + CW'(1);
                            end
                            if (w_last_tile) begin
                                r_state <= StFin;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= StIssue;
                                r_feed_start <= 1'b1;
                                r_acc_clear  <= 1'b1;
                            end
                        end
                    end
                    StFin: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign feed_start = r_feed_start;
    assign acc_clear  = r_acc_clear;
    assign wb_req     = r_wb_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign aborted    = r_aborted;
    assign tile_row   = r_tile_row;
    assign tile_col   = r_tile_col;
    assign tile_k     = r_tile_k;
    assign state_dbg  = r_state;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] r_perf_busy, r_perf_stall;
    logic        w_stall;

    assign w_stall = ((r_state == StFeed) && !w_feed_cmp) || ((r_state == StWb) && !wb_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == StIdle) && start && w_cfg_ok) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state != StIdle) && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
            if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_tile_sched.sv
// Self-checking bench for tile_sched: job table plus abort/cfg_err/reset sequences,
// with feeder and writeback models driven from a per-cycle monitor.
module tb_tile_sched;

    localparam int CW  = 8;
    localparam int DC  = 4;
    localparam int DRW = 3;

    logic          clk;
    logic          rst, start, abort;
    logic [CW-1:0] cfg_rows, cfg_cols, cfg_ks;
    logic          feed_start, feed_done_a, feed_done_b;
    logic [CW-1:0] tile_row, tile_col, tile_k;
    logic          acc_clear, wb_req, wb_ack, busy, done, cfg_err, aborted;
    logic [2:0]    state_dbg;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]   perf_busy_cyc, perf_stall_cyc;
`endif

    tile_sched #(.CW(CW), .DRAIN_CYC(DC), .DRW(DRW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_ks(cfg_ks),
        .feed_start(feed_start), .feed_done_a(feed_done_a), .feed_done_b(feed_done_b),
        .tile_row(tile_row), .tile_col(tile_col), .tile_k(tile_k),
        .acc_clear(acc_clear), .wb_req(wb_req), .wb_ack(wb_ack), .busy(busy), .done(done),
        .cfg_err(cfg_err), .aborted(aborted), .state_dbg(state_dbg)
`ifdef TILE_SCHED_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int              rows;
        int              cols;
        int              ks;
        logic [2:0][3:0] da;
        logic [2:0][3:0] db;
        int              ack;
        int              exp_feeds;
        int              exp_acc;
    } job_t;

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] c;
    } tile_t;

    int n_chk, n_fail, cyc;
    job_t cur;
    tile_t sb[$];
    int n_feeds, n_acc, n_done, n_abort, fit, ta, tb, fs_cyc;
    int exp_fs, exp_wb, exp_done, tack, wb_hi, start_cyc, done_cyc;
    bit pending, wreq_q;
    logic [CW-1:0] wb_row, wb_col, wb_k;
`ifdef TILE_SCHED_PERF_EN
    int m_stall;
`endif

    function automatic job_t mk(input int r, input int c, input int k,
                                input int a0, input int a1, input int a2,
                                input int b0, input int b1, input int b2,
                                input int ack, input int feeds, input int acc);
        job_t j;
        j.rows = r; j.cols = c; j.ks = k;
        j.da[0] = 4'(a0); j.da[1] = 4'(a1); j.da[2] = 4'(a2);
        j.db[0] = 4'(b0); j.db[1] = 4'(b1); j.db[2] = 4'(b2);
        j.ack = ack; j.exp_feeds = feeds; j.exp_acc = acc;
        return j;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Feeder and writeback models plus event checks, evaluated once per cycle at negedge.
    task automatic monitor();
        int f;
        tile_t t;
        if (feed_start) begin
            check("feed_start_time", cyc, exp_fs);
            check("acc_clear", acc_clear, fit == 0);
            check("tile_k_at_feed", tile_k, fit);
            if (acc_clear) n_acc++;
            ta = cyc + int'(cur.da[n_feeds % 3]);
            tb = cyc + int'(cur.db[n_feeds % 3]);
            n_feeds++;
            fs_cyc  = cyc;
            pending = 1'b1;
            exp_fs  = -1;
        end
        feed_done_a = pending && (cyc == ta);
        feed_done_b = pending && (cyc == tb);
        f = (ta > tb) ? ta : tb;
        if (pending && cyc == f) begin
            pending = 1'b0;
`ifdef TILE_SCHED_PERF_EN
            m_stall += f - fs_cyc - 1;
`endif
            if (fit < cur.ks - 1) begin
                fit++;
                exp_fs = cyc + 1;
            end else begin
                exp_wb = cyc + DC + 1;
            end
        end
        if (wb_req && !wreq_q) begin
            check("wb_req_time", cyc, exp_wb);
            exp_wb = -1;
            tack   = cyc + cur.ack;
            wb_hi  = 0;
            wb_row = tile_row; wb_col = tile_col; wb_k = tile_k;
        end else if (wb_req) begin
            check("wb_idx_stable", {tile_row, tile_col, tile_k}, {wb_row, wb_col, wb_k});
        end
        if (wb_req) wb_hi++;
        wb_ack = wb_req && (cyc == tack);
        if (wb_ack) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_tile", 1, 0);
            end else begin
                t = sb.pop_front();
                check("wb_tile_row", tile_row, t.r);
                check("wb_tile_col", tile_col, t.c);
            end
            check("wb_tile_k", tile_k, cur.ks - 1);
            check("wb_req_len", wb_hi, cur.ack + 1);
`ifdef TILE_SCHED_PERF_EN
            m_stall += cur.ack;
`endif
            fit = 0;
            if (sb.size() == 0) exp_done = cyc + 1;
            else exp_fs = cyc + 1;
        end
        if (done) begin
            n_done++;
            check("done_time", cyc, exp_done);
            exp_done = -1;
            done_cyc = cyc;
        end
        if (aborted) n_abort++;
        wreq_q = wb_req;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic reset_model();
        n_feeds = 0; n_acc = 0; n_done = 0; n_abort = 0; fit = 0; pending = 1'b0;
        exp_fs = -1; exp_wb = -1; exp_done = -1; tack = -1; ta = -1; tb = -1;
        feed_done_a = 1'b0; feed_done_b = 1'b0; wb_ack = 1'b0;
        sb.delete();
`ifdef TILE_SCHED_PERF_EN
        m_stall = 0;
`endif
    endtask

    task automatic launch(input job_t j);
        tile_t t;
        reset_model();
        cur = j;
        for (int r = 0; r < j.rows; r++) begin
            for (int c = 0; c < j.cols; c++) begin
                t.r = CW'(r); t.c = CW'(c);
                sb.push_back(t);
            end
        end
        cfg_rows = CW'(j.rows); cfg_cols = CW'(j.cols); cfg_ks = CW'(j.ks);
        start = 1'b1;
        start_cyc = cyc;
        exp_fs = cyc + 1;
        step();
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_feed_start", feed_start, 1);
    endtask

    task automatic finish_job(input job_t j);
        int budget = 0;
        while (n_done == 0 && budget < 3000) begin
            step();
            budget++;
        end
        check("job_done_count", n_done, 1);
        check("job_feed_count", n_feeds, j.exp_feeds);
        check("job_acc_clear_count", n_acc, j.exp_acc);
        check("job_tiles_left", sb.size(), 0);
        check("job_no_abort", n_abort, 0);
        check("done_after_start", done_cyc > start_cyc, 1);
        step();
        check("idle_after_done", {busy, done, state_dbg}, 0);
`ifdef TILE_SCHED_PERF_EN
        check("perf_busy_cyc", perf_busy_cyc, done_cyc - start_cyc);
        check("perf_stall_cyc", perf_stall_cyc, m_stall);
`endif
    endtask

    job_t jobs[4];
    job_t jb;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; wreq_q = 1'b0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_rows = '0; cfg_cols = '0; cfg_ks = '0;
        cur = mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        reset_model();

        jobs[0] = mk(1, 1, 1, 3, 3, 3, 3, 3, 3, 0, 1, 1);   // single tile
        jobs[1] = mk(2, 2, 3, 1, 1, 1, 1, 1, 1, 0, 12, 4);  // full job, immediate dones
        jobs[2] = mk(1, 1, 3, 2, 4, 6, 7, 4, 3, 0, 3, 1);   // a first, together, b first
        jobs[3] = mk(1, 2, 1, 1, 1, 1, 2, 2, 2, 3, 2, 2);   // writeback backpressure

        repeat (3) step();
        check("reset_outputs", {feed_start, acc_clear, wb_req, busy, done, cfg_err, aborted,
                                state_dbg, tile_row, tile_col, tile_k}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            launch(jobs[i]);
            finish_job(jobs[i]);
        end

        // Abort while draining.
        jb = mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1);
        launch(jb);
        for (int b = 0; b < 100 && state_dbg != 3'd3; b++) step();
        check("reach_drain", state_dbg, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_quiet", {busy, state_dbg, wb_req, done, feed_start}, 0);
        repeat (DC + 4) step();
        check("abort_no_done", n_done, 0);
        check("abort_single_pulse", n_abort, 1);
        check("abort_no_wb", sb.size(), 1);

        // Zero counts are rejected.
        for (int z = 0; z < 3; z++) begin
            cfg_rows = (z == 0) ? '0 : CW'(2);
            cfg_cols = (z == 1) ? '0 : CW'(2);
            cfg_ks   = (z == 2) ? '0 : CW'(2);
            start = 1'b1;
            step();
            start = 1'b0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_idle", {busy, feed_start, state_dbg}, 0);
            step();
            check("cfg_err_one_cycle", {cfg_err, busy}, 0);
        end

        jb = mk(2, 1, 2, 1, 2, 1, 2, 1, 1, 1, 4, 2);
        launch(jb);
        finish_job(jb);

        // Abort with wb_req pending drops the request.
        jb = mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 50, 1, 1);
        launch(jb);
        for (int b = 0; b < 100 && !wb_req; b++) step();
        check("wb_pending_before_abort", wb_req, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_drops_wb", {wb_req, busy, aborted}, 3'b001);

        // Reset mid-job.
        launch(jobs[1]);
        repeat (6) step();
        rst = 1'b1;
        step();
        check("midjob_reset_outputs", {feed_start, acc_clear, wb_req, busy, done, cfg_err,
                                       aborted, state_dbg, tile_row, tile_col, tile_k}, 0);
        rst = 1'b0;
        repeat (4) step();
        check("midjob_reset_no_done", n_done, 0);
        check("midjob_reset_no_abort", n_abort, 0);
        check("midjob_reset_idle", {busy, state_dbg}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
